pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage; successor to the fixed 16-bit PC register. It owns the next-PC decision: sequential increment, hold on hazard stall, branch/jump redirect, and call/return through a small return-address stack (RAS). It sits ahead of instruction memory and drives the fetch address every cycle.

## Interface
- WIDTH, 16, PC width in bits
- INC, 2, sequential increment added to the PC each advancing cycle
- RESET_VEC, 0, PC value after reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clk  in  1  clock; all state updates on the falling edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low (sampled on the falling edge of clk)
- stall  in  1  hold PC and RAS unchanged (data hazard)
- redirect  in  1  taken branch/jump this cycle
- redirect_tgt  in  WIDTH  branch/jump/call target
- call  in  1  push return address; valid only with redirect
- ret  in  1  return; next PC from RAS top
- pc_out  out  WIDTH  current fetch PC (registered)
- pc_plus_inc  out  WIDTH  pc_out + INC (combinational, mod 2^WIDTH)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries

## Operation
- Reset: pc_out = RESET_VEC, RAS count = 0, ras_empty = 1, ras_full = 0; all RAS entries cleared to 0.
- Next-PC priority (highest first): reset > stall > ret > redirect > sequential.
  - stall: pc_out and RAS unchanged; call/ret/redirect ignored.
  - ret, RAS non-empty: pc_out ← top entry; pop (count − 1).
  - ret, RAS empty: pc_out ← redirect_tgt; no pop; count stays 0.
  - redirect: pc_out ← redirect_tgt; if call, push pc_out + INC.
  - otherwise: pc_out ← pc_out + INC.
- call without redirect: ignored (no push, sequential advance).
- call and ret same cycle: ret wins, call ignored.
- Push when full: circular overwrite of oldest entry; count stays RAS_DEPTH; ras_full stays 1.
- Arithmetic: all sums truncated to WIDTH; PC wraps from 2^WIDTH − INC to 0 with no flag.
- RAS implemented as circular buffer with top pointer (log2 RAS_DEPTH bits) and count (log2 RAS_DEPTH + 1 bits).

## Timing
- Inputs sampled on falling edge N; pc_out, RAS, flags valid after edge N. Latency 1 cycle from request to new pc_out.
- pc_plus_inc follows pc_out combinationally, zero latency.
- ras_empty/ras_full registered alongside count; reflect state after the same edge.
- rst_n low mid-operation: next falling edge forces reset values regardless of stall/redirect/ret; pending requests discarded.
- rst_n released: first advance on the following falling edge, from RESET_VEC.

## Configuration
- PC_RAS_EN defined: RAS instantiated, behaviour as above.
- PC_RAS_EN undefined: no RAS storage; call ignored; ret behaves as redirect to redirect_tgt (same priority slot as ret); ras_empty tied 1, ras_full tied 0. Port list identical in both builds.

## Structure
- Shared package pc_pkg: next-PC select encoding (NPC_HOLD, NPC_RET, NPC_REDIR, NPC_SEQ), default RESET_VEC and INC constants.
- One sub-module ras_stack (push, pop, push_data, top, empty, full; parameters WIDTH, RAS_DEPTH); instantiated only under PC_RAS_EN.
- Top level: priority select plus PC register.

## Test plan
- Reset then 4 free-running cycles, WIDTH=16, INC=2 -> pc_out 0x0000, 0x0002, 0x0004, 0x0006, 0x0008.
- stall high 3 cycles at pc_out=0x0010 with redirect=1, redirect_tgt=0x0100 -> pc_out stays 0x0010, RAS unchanged; releases to 0x0012.
- call+redirect at 0x0020 to 0x0400, advance 2 cycles, ret -> pc_out 0x0400, 0x0402, 0x0404, then 0x0022; ras_empty 1→0→1.
- 5 nested calls with RAS_DEPTH=4 then 5 rets -> first 4 rets return newest-first; ras_full stays 1 on 5th push; 5th ret on empty goes to redirect_tgt.
- pc_out=0xFFFE, advance -> 0x0000; assert rst_n low with redirect=1 mid-stream -> pc_out=RESET_VEC, ras_empty=1 next edge.
- Build without PC_RAS_EN: call+redirect then ret with redirect_tgt=0x0300 -> pc_out 0x0300; ras_empty=1 throughout.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program-counter generator.
//   npc_sel_e            next-PC source select (hold / return / redirect / sequential)
//   PC_DEFAULT_RESET_VEC default PC value after reset
//   PC_DEFAULT_INC       default sequential increment
package pc_pkg;

    typedef enum logic [1:0] {
        NPC_HOLD  = 2'd0,
        NPC_RET   = 2'd1,
        NPC_REDIR = 2'd2,
        NPC_SEQ   = 2'd3
    } npc_sel_e;

    localparam int unsigned PC_DEFAULT_RESET_VEC = 0;
    localparam int unsigned PC_DEFAULT_INC       = 2;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: request/response bundle between the fetch control logic and pc_gen.
//   stall, redirect, redirect_tgt, call, ret : requests into pc_gen
//   pc_out, pc_plus_inc, ras_empty, ras_full : PC and return-stack status out of pc_gen
// Request semantics: there is no valid/ready pair. Every request input is sampled
// on every falling clock edge and acted on in that same edge; nothing is ever
// back-pressured or queued, so a request held for N edges is acted on N times.
// Modports: master = fetch control (drives requests), slave = pc_gen.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 16
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_tgt;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus_inc;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        output stall, redirect, redirect_tgt, call, ret,
        input  pc_out, pc_plus_inc, ras_empty, ras_full
    );

    modport slave (
        input  stall, redirect, redirect_tgt, call, ret,
        output pc_out, pc_plus_inc, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_gen_ras_stack.sv
// ras_stack: return-address stack as a circular buffer with a top pointer and
// an occupancy count. Updates on the falling edge of clk; synchronous active-low reset.
//   clk, rst_n  clock / reset
//   push        write push_data as the new top (overwrites the oldest entry when full)
//   pop         discard the top entry (ignored when empty)
//   push_data   return address to store
//   top         current top entry
//   empty, full occupancy flags derived from the registered count
module ras_stack #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    top_ptr;
    logic [PW-1:0]    push_ptr;
    logic [CW-1:0]    count;

    // The pointer wraps naturally at RAS_DEPTH (power of two), so a push when
    // full lands on the slot holding the oldest entry.
    assign push_ptr = top_ptr + PW'(1);

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            top_ptr <= '0;
            count   <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[push_ptr] <= push_data;
            top_ptr       <= push_ptr;
            if (count != CNT_FULL) begin
                count <= count + CW'(1);
            end
        end else if (pop && (count != '0)) begin
            top_ptr <= top_ptr - PW'(1);
            count   <= count - CW'(1);
        end
    end

    assign top   = mem[top_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator. Chooses the next PC from
// hold (stall), return (RAS top or redirect_tgt), redirect, or sequential
// increment, in that priority order, and registers it on the falling edge.
//   clk    clock; all state updates on the falling edge
//   rst_n  synchronous active-low reset
//   bus    pc_gen_if.slave: stall, redirect, redirect_tgt, call, ret in;
//          pc_out, pc_plus_inc, ras_empty, ras_full out
// Build option: define PC_RAS_EN to include the return-address stack. Without
// it, call is ignored, ret redirects to redirect_tgt, ras_empty=1, ras_full=0.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned INC       = PC_DEFAULT_INC,
    parameter int unsigned RESET_VEC = PC_DEFAULT_RESET_VEC,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    pc_gen_if.slave bus
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    npc_sel_e         npc_sel;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty_w;
    logic             ras_full_w;
    logic             ras_push;
    logic             ras_pop;

    // Truncation to WIDTH gives the required silent wrap.
    assign pc_inc = pc_q + WIDTH'(INC);

    always_comb begin
        npc_sel = NPC_SEQ;
        if (bus.stall) begin
            npc_sel = NPC_HOLD;
        end else if (bus.ret) begin
            npc_sel = NPC_RET;
        end else if (bus.redirect) begin
            npc_sel = NPC_REDIR;
        end
    end

    always_comb begin
        pc_next = pc_inc;
        unique case (npc_sel)
            NPC_HOLD:  pc_next = pc_q;
            // An empty stack (or no stack at all) falls back to the redirect target.
            NPC_RET:   pc_next = ras_empty_w ? bus.redirect_tgt : ras_top;
            NPC_REDIR: pc_next = bus.redirect_tgt;
            NPC_SEQ:   pc_next = pc_inc;
            default:   pc_next = pc_inc;
        endcase
    end

    // A call only counts when it wins the select as a redirect; with stall or
    // ret in the same cycle it is dropped.
    assign ras_push = (npc_sel == NPC_REDIR) && bus.call;
    assign ras_pop  = (npc_sel == NPC_RET) && !ras_empty_w;

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            pc_q <= WIDTH'(RESET_VEC);
        end else begin
            pc_q <= pc_next;
        end
    end

`ifdef PC_RAS_EN
    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty_w),
        .full      (ras_full_w)
    );
`else
    logic unused_ras;
    assign ras_top     = '0;
    assign ras_empty_w = 1'b1;
    assign ras_full_w  = 1'b0;
    assign unused_ras  = &{1'b0, ras_push, ras_pop};
`endif

    assign bus.pc_out      = pc_q;
    assign bus.pc_plus_inc = pc_inc;
    assign bus.ras_empty   = ras_empty_w;
    assign bus.ras_full    = ras_full_w;
endmodule
